shift_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one combinational bidirectional barrel shifter (8-bit data, 3-bit shift amount, direction bit) between NREQ requesters. Each requester submits an operand, shift amount and direction over a valid/ready handshake. The block grants one requester at a time, drives the external shifter from registered operands, captures the result and returns it tagged with the requester id over a valid/ready response channel. It sits between the ALU-side clients and the single shared shifter instance.

---
 rtl/shift_arbiter.sv | 150 +++++++++++++++
 tb/tb_shift_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_arbiter.sv
// shift_arbiter: round-robin arbiter and sequencer that lets NREQ requesters
// share one external combinational barrel shifter. Each granted request is
// registered, presented to the shifter, and its result returned over a
// valid/ready response channel tagged with the requester id.
// Optional build macro: SHIFT_BYPASS_EN -- a request granted with a zero
// shift amount skips the SHIFT state and responds one cycle after acceptance.
module shift_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int SHW   = 3,
    parameter int IDW   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_data,
    input  logic [NREQ*SHW-1:0]   req_shamt,
    input  logic [NREQ-1:0]       req_dir,
    output logic [WIDTH-1:0]      sh_in,
    output logic [SHW-1:0]        sh_shamt,
    output logic                  sh_dir,
    input  logic [WIDTH-1:0]      sh_out,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [WIDTH-1:0]      resp_data,
    output logic [IDW-1:0]        resp_id
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_op_data;
    logic [SHW-1:0]   r_op_shamt;
    logic             r_op_dir;
    logic [IDW-1:0]   r_op_id;
    logic [IDW-1:0]   r_last_grant;
    logic             r_resp_valid;
    logic [WIDTH-1:0] r_resp_data;
    logic [IDW-1:0]   r_resp_id;

    logic             w_found;
    logic [IDW-1:0]   w_win;
    logic [IDW-1:0]   w_idx;
    logic             w_grant;
    logic [NREQ-1:0]  w_ready;
    logic [WIDTH-1:0] w_win_data;
    logic [SHW-1:0]   w_win_shamt;
    logic             w_win_dir;

    // Rotating-priority search: first valid requester after the last grant.
    // The IDW-bit add wraps naturally because NREQ is a power of two.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = r_last_grant + IDW'(k);
            if (!w_found && req_valid[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    // A grant is only offered from IDLE and never while reset is asserted.
    assign w_grant     = (r_state == IDLE) && w_found && !rst;
    assign w_win_data  = req_data[int'(w_win)*WIDTH +: WIDTH];
    assign w_win_shamt = req_shamt[int'(w_win)*SHW +: SHW];
    assign w_win_dir   = req_dir[w_win];

    // One-hot accept to the winning requester only.
    always_comb begin
        w_ready = '0;
        if (w_grant) begin
            w_ready[w_win] = 1'b1;
        end
    end

    // Sequencer: IDLE accepts a winner, SHIFT captures the shifter result,
    // RESP holds the result until the consumer takes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_op_data    <= '0;
            r_op_shamt   <= '0;
            r_op_dir     <= 1'b0;
            r_op_id      <= '0;
            r_last_grant <= IDW'(NREQ - 1);
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_resp_id    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_op_data    <= w_win_data;
                        r_op_shamt   <= w_win_shamt;
                        r_op_dir     <= w_win_dir;
                        r_op_id      <= w_win;
                        r_last_grant <= w_win;
`ifdef SHIFT_BYPASS_EN
                        if (w_win_shamt == '0) begin
                            r_resp_data  <= w_win_data;
                            r_resp_id    <= w_win;
                            r_resp_valid <= 1'b1;
                            r_state      <= RESP;
                        end else begin
                            r_state <= SHIFT;
                        end
`else
                        r_state <= SHIFT;
`endif
                    end
                end
                SHIFT: begin
                    r_resp_data  <= sh_out;
                    r_resp_id    <= r_op_id;
                    r_resp_valid <= 1'b1;
                    r_state      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_state      <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Shifter inputs come straight from the operand registers so they are
    // stable for the whole SHIFT cycle.
    assign sh_in      = r_op_data;
    assign sh_shamt   = r_op_shamt;
    assign sh_dir     = r_op_dir;

    assign req_ready  = w_ready;
    assign resp_valid = r_resp_valid;
    assign resp_data  = r_resp_data;
    assign resp_id    = r_resp_id;

endmodule

// File: tb/tb_shift_arbiter.sv
// Testbench for shift_arbiter: vector table, hand-written corner sequences
// (fairness, backpressure, mid-operation reset) and a randomized run against
// a queue-based reference model. Honours SHIFT_BYPASS_EN for latency.
module tb_shift_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int SHW   = 3;
    localparam int IDW   = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ*SHW-1:0]   req_shamt;
    logic [NREQ-1:0]       req_dir;
    logic [WIDTH-1:0]      sh_in;
    logic [SHW-1:0]        sh_shamt;
    logic                  sh_dir;
    logic [WIDTH-1:0]      sh_out;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [WIDTH-1:0]      resp_data;
    logic [IDW-1:0]        resp_id;

    int n_tests = 0;
    int n_fail  = 0;

    shift_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .SHW(SHW), .IDW(IDW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .req_shamt(req_shamt), .req_dir(req_dir),
        .sh_in(sh_in), .sh_shamt(sh_shamt), .sh_dir(sh_dir), .sh_out(sh_out),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_id(resp_id)
    );

    always #5 clk = ~clk;

    // External shared shifter: logical zero-fill shift.
    assign sh_out = sh_dir ? (sh_in >> sh_shamt) : (sh_in << sh_shamt);

    typedef struct {
        int         idx;
        logic [7:0] d;
        logic [2:0] s;
        logic       dr;
        logic [7:0] exp;
    } vec_t;

    typedef struct {
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;

    vec_t vecs[8];
    exp_t q[$];

    function automatic logic [7:0] ref_shift(input logic [7:0] d, input int s, input logic dr);
        int v;
        v = int'(d);
        if (dr) v = v / (1 << s);
        else    v = (v * (1 << s)) % 256;
        return v[7:0];
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [7:0] d, input logic [2:0] s, input logic dr);
        req_data[i*WIDTH +: WIDTH] = d;
        req_shamt[i*SHW +: SHW]    = s;
        req_dir[i]                 = dr;
    endtask

    function automatic int exp_latency(input logic [2:0] s);
        int l;
        l = 2;
`ifdef SHIFT_BYPASS_EN
        if (s == 3'd0) l = 1;
`endif
        return l;
    endfunction

    // Single-requester transaction; starts and ends just after a rising edge
    // with the DUT idle and resp_ready high.
    task automatic run_txn(input int idx, input logic [7:0] d, input logic [2:0] s,
                           input logic dr, input logic [7:0] exp_d, input string nm);
        int cnt;
        int lat;
        set_req(idx, d, s, dr);
        req_valid      = '0;
        req_valid[idx] = 1'b1;
        #1;
        cnt = 0;
        while (!req_ready[idx] && cnt < 10) begin
            @(posedge clk); #1;
            cnt++;
        end
        check({nm, "_ready"}, 32'(req_ready), 32'(1) << idx);
        @(posedge clk); #1;
        lat = 1;
        check({nm, "_pulse"}, 32'(req_ready), 32'd0);
        req_valid = '0;
        while (!resp_valid && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        check({nm, "_latency"}, 32'(lat), 32'(exp_latency(s)));
        check({nm, "_data"}, 32'(resp_data), 32'(exp_d));
        check({nm, "_id"}, 32'(resp_id), 32'(idx));
        @(posedge clk); #1;
        check({nm, "_done"}, 32'(resp_valid), 32'd0);
    endtask

    int         cnt;
    int         age;
    int         grants;
    int         m_last;
    int         w;
    logic [3:0] exp_rdy;
    logic [3:0] clr;

    initial begin
        rst        = 1'b1;
        req_valid  = '0;
        req_data   = '0;
        req_shamt  = '0;
        req_dir    = '0;
        resp_ready = 1'b1;

        vecs[0] = '{0, 8'd5,   3'd4, 1'b0, 8'b0101_0000};
        vecs[1] = '{1, 8'd30,  3'd3, 1'b1, 8'b0000_0011};
        vecs[2] = '{2, 8'd128, 3'd2, 1'b0, 8'd0};
        vecs[3] = '{3, 8'd25,  3'd0, 1'b0, 8'd25};
        vecs[4] = '{0, 8'hFF,  3'd7, 1'b1, 8'h01};
        vecs[5] = '{1, 8'hFF,  3'd7, 1'b0, 8'h80};
        vecs[6] = '{2, 8'hA5,  3'd0, 1'b1, 8'hA5};
        vecs[7] = '{3, 8'h81,  3'd1, 1'b1, 8'h40};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_data", 32'(resp_data), 32'd0);
        check("rst_resp_id", 32'(resp_id), 32'd0);
        check("rst_sh_in", 32'(sh_in), 32'd0);
        req_valid = 4'hF;
        #1;
        check("rst_ready", 32'(req_ready), 32'd0);
        req_valid = '0;
        rst = 1'b0;
        @(posedge clk); #1;

        // Vector table
        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i].idx, vecs[i].d, vecs[i].s, vecs[i].dr, vecs[i].exp,
                    $sformatf("vec%0d", i));
        end

        // Fairness: all requesters held valid from reset
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) set_req(i, 8'(10 * (i + 1)), 3'd1, 1'b0);
        req_valid  = 4'hF;
        resp_ready = 1'b1;
        #1;
        for (int g = 0; g < 5; g++) begin
            cnt = 0;
            while (req_ready == '0 && cnt < 10) begin
                @(posedge clk); #1;
                cnt++;
            end
            check($sformatf("rr_grant%0d", g), 32'(req_ready), 32'(1) << (g % 4));
            @(posedge clk); #1;
            cnt = 0;
            while (!resp_valid && cnt < 8) begin
                check($sformatf("rr_busy%0d", g), 32'(req_ready), 32'd0);
                @(posedge clk); #1;
                cnt++;
            end
            check($sformatf("rr_id%0d", g), 32'(resp_id), 32'(g % 4));
            check($sformatf("rr_data%0d", g), 32'(resp_data),
                  32'(ref_shift(8'(10 * ((g % 4) + 1)), 1, 1'b0)));
            @(posedge clk); #1;
        end
        req_valid = '0;
        @(posedge clk); #1;

        // Backpressure (last grant was 0, so requester 1 wins)
        resp_ready = 1'b0;
        set_req(1, 8'd63, 3'd5, 1'b1);
        req_valid = 4'b0010;
        #1;
        check("bp_grant", 32'(req_ready), 32'b0010);
        @(posedge clk); #1;
        set_req(2, 8'h11, 3'd1, 1'b0);
        req_valid = 4'b0100;
        cnt = 0;
        while (!resp_valid && cnt < 8) begin
            @(posedge clk); #1;
            cnt++;
        end
        for (int c = 0; c < 5; c++) begin
            check($sformatf("bp_valid%0d", c), 32'(resp_valid), 32'd1);
            check($sformatf("bp_data%0d", c), 32'(resp_data), 32'd1);
            check($sformatf("bp_id%0d", c), 32'(resp_id), 32'd1);
            check($sformatf("bp_ready%0d", c), 32'(req_ready), 32'd0);
            @(posedge clk); #1;
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", 32'(resp_valid), 32'd0);
        check("bp_release_idle", 32'(req_ready), 32'b0100);
        req_valid = '0;
        @(posedge clk); #1;

        // Reset while in SHIFT (last grant 1, so requester 2 wins)
        set_req(2, 8'd52, 3'd1, 1'b0);
        req_valid = 4'b0100;
        #1;
        check("mr_grant", 32'(req_ready), 32'b0100);
        @(posedge clk); #1;
        rst = 1'b1;
        set_req(1, 8'd7, 3'd1, 1'b0);
        set_req(3, 8'd9, 3'd1, 1'b0);
        req_valid = 4'b1010;
        #1;
        check("mr_ready_in_rst", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        check("mr_resp_valid", 32'(resp_valid), 32'd0);
        check("mr_resp_data", 32'(resp_data), 32'd0);
        rst = 1'b0;
        #1;
        check("mr_ptr_reset", 32'(req_ready), 32'b0010);
        req_valid = '0;
        @(posedge clk); #1;

        // Randomized run against the queue model
        rst = 1'b1;
        @(posedge clk); #1;
        rst    = 1'b0;
        m_last = NREQ - 1;
        age    = 0;
        grants = 0;
        q.delete();
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        set_req(i, 8'($urandom), 3'($urandom), 1'($urandom));
                        req_valid[i] = 1'b1;
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            resp_ready = (cyc >= 580) || ($urandom_range(0, 2) != 0);
            if (cyc >= 570) req_valid = '0;
            #1;
            exp_rdy = '0;
            w = -1;
            if (q.size() == 0) begin
                for (int k = 1; k <= NREQ; k++) begin
                    if (w < 0 && req_valid[(m_last + k) % NREQ]) w = (m_last + k) % NREQ;
                end
                if (w >= 0) exp_rdy[w] = 1'b1;
            end
            check("rnd_grant", 32'(req_ready), 32'(exp_rdy));
            if (resp_valid) begin
                age = 0;
                if (q.size() == 0) begin
                    check("rnd_spurious_resp", 32'(resp_valid), 32'd0);
                end else begin
                    check("rnd_resp_data", 32'(resp_data), 32'(q[0].data));
                    check("rnd_resp_id", 32'(resp_id), 32'(q[0].id));
                    if (resp_ready) void'(q.pop_front());
                end
            end else if (q.size() != 0) begin
                age++;
                if (age == 3) check("rnd_resp_timeout", 32'(age), 32'd2);
            end
            clr = '0;
            if (w >= 0) begin
                q.push_back('{2'(w), ref_shift(req_data[w*WIDTH +: WIDTH],
                                               int'(req_shamt[w*SHW +: SHW]), req_dir[w])});
                m_last = w;
                grants++;
                clr[w] = 1'b1;
            end
            @(posedge clk); #1;
            req_valid = req_valid & ~clr;
        end
        check("rnd_drained", 32'(q.size()), 32'd0);
        check("rnd_enough_grants", 32'(grants >= 40), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
